// File: rtl/fsd_text_buffer_pkg.sv
// Shared constants and state encoding for the fourteen-segment text line buffer.
package fsd_text_buffer_pkg;

  localparam int unsigned FsdDigitCount = 4;
  localparam int unsigned AsciiBitWidth = 8;
  localparam int unsigned FsdTextDepth  = 16;
  localparam int unsigned FsdScrollDiv  = 250;
  localparam logic [7:0]  AsciiSpace    = 8'h20;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StScroll = 1'b1
  } fsd_text_state_e;

endpackage

// File: rtl/fsd_scroll_timer.sv
// Modulo-ScrollDiv tick generator; step_o pulses for one cycle at terminal count.
module fsd_scroll_timer #(
  parameter int unsigned ScrollDiv = 250
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic step_o
);

  localparam int unsigned    TickW   = $clog2(ScrollDiv);
  localparam logic [TickW-1:0] TickMax = TickW'(ScrollDiv - 1);

  logic [TickW-1:0] tick_q, tick_d;

  // Count up, wrapping at terminal count; restart forces the count back to zero.
  always_comb begin
    tick_d = tick_q + 1'b1;
    if (restart_i || (tick_q == TickMax)) begin
      tick_d = '0;
    end
  end

  // Tick counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign step_o = (tick_q == TickMax) && !restart_i;

endmodule

// File: rtl/fsd_text_buffer.sv
// Text line buffer feeding the fourteen-segment encoder: tail view or marquee scroll.
module fsd_text_buffer
  import fsd_text_buffer_pkg::*;
#(
  parameter int unsigned DigitCount = FsdDigitCount,
  parameter int unsigned CharWidth  = AsciiBitWidth,
  parameter int unsigned Depth      = FsdTextDepth,
  parameter int unsigned ScrollDiv  = FsdScrollDiv
) (
  input  logic                             clk_ctrl_i,
  input  logic                             reset_i,
  input  logic [CharWidth-1:0]             char_in_i,
  input  logic                             char_valid_i,
  input  logic                             clear_i,
  input  logic                             scroll_en_i,
  output logic [DigitCount*CharWidth-1:0]  chars_o,
  output logic [DigitCount-1:0]            dp_o,
  output logic [$clog2(Depth+1)-1:0]       count_o,
  output logic                             full_o
);

  localparam int unsigned CountW = $clog2(Depth + 1);
  localparam int unsigned OffW   = $clog2(Depth + DigitCount);
  localparam int unsigned IdxW   = $clog2(Depth);
  localparam logic [CharWidth-1:0] Space = CharWidth'(AsciiSpace);

  logic [CharWidth-1:0] entries_q [Depth];
  logic [CharWidth-1:0] entries_d [Depth];
  logic [CountW-1:0]    count_q, count_d;
  logic [OffW-1:0]      off_q, off_d;
  fsd_text_state_e      state_q, state_d;

  logic [DigitCount*CharWidth-1:0] chars_q, chars_d;
  logic [DigitCount-1:0]           dp_q, dp_d;
  logic                            full_q, full_d;

  logic          accept, restart, step;
  logic [OffW:0] len_q, len_d;

  assign accept  = char_valid_i && (char_in_i != '0);
  assign restart = (state_q != StScroll) || (state_d != StScroll);
  assign len_q   = (OffW+1)'(count_q) + (OffW+1)'(DigitCount);
  assign len_d   = (OffW+1)'(count_d) + (OffW+1)'(DigitCount);

  fsd_scroll_timer #(
    .ScrollDiv (ScrollDiv)
  ) u_timer (
    .clk_i     (clk_ctrl_i),
    .rst_i     (reset_i),
    .restart_i (restart),
    .step_o    (step)
  );

  // Shift array: clear beats append; the oldest entry falls off the end when full.
  always_comb begin
    entries_d = entries_q;
    count_d   = count_q;
    if (clear_i) begin
      for (int i = 0; i < Depth; i++) entries_d[i] = Space;
      count_d = '0;
    end else if (accept) begin
      entries_d[0] = char_in_i;
      for (int i = 1; i < Depth; i++) entries_d[i] = entries_q[i-1];
      if (count_q != CountW'(Depth)) count_d = count_q + 1'b1;
    end
  end

  // Mode FSM and scroll offset; any edit snaps back to the tail view.
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    unique case (state_q)
      StIdle: begin
        if (!clear_i && !accept && scroll_en_i && (count_q > CountW'(DigitCount))) begin
          state_d = StScroll;
          off_d   = '0;
        end
      end
      StScroll: begin
        if (clear_i || accept || !scroll_en_i) begin
          state_d = StIdle;
          off_d   = '0;
        end else if (step) begin
          off_d = ({1'b0, off_q} == len_q - 1'b1) ? '0 : off_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        off_d   = '0;
      end
    endcase
  end

  // Per-slot window select, built from next-state values so outputs lag events by one edge.
  for (genvar k = 0; k < DigitCount; k++) begin : g_slot
    localparam int unsigned J = DigitCount - 1 - k;
    logic [OffW:0]         vraw, vidx;
    logic [IdxW-1:0]       eidx;
    logic [CharWidth-1:0]  idle_c, scroll_c;

    // V index = (o + j) mod L by a single compare-and-subtract (o < L, j < L).
    always_comb begin
      vraw     = {1'b0, off_d} + (OffW+1)'(J);
      vidx     = (vraw >= len_d) ? (vraw - len_d) : vraw;
      eidx     = IdxW'((OffW+1)'(count_d) - vidx - 1'b1);
      scroll_c = Space;
      if (vidx < (OffW+1)'(count_d)) scroll_c = entries_d[eidx];
      idle_c   = (CountW'(k) < count_d) ? entries_d[k] : Space;
    end

    assign chars_d[k*CharWidth +: CharWidth] = (state_d == StScroll) ? scroll_c : idle_c;
  end

  assign dp_d   = (state_d == StScroll) ? DigitCount'(1) : '0;
  assign full_d = (count_d == CountW'(Depth));

  // State, storage and registered outputs.
  always_ff @(posedge clk_ctrl_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < Depth; i++) entries_q[i] <= Space;
      count_q <= '0;
      off_q   <= '0;
      state_q <= StIdle;
      chars_q <= {DigitCount{Space}};
      dp_q    <= '0;
      full_q  <= 1'b0;
    end else begin
      for (int i = 0; i < Depth; i++) entries_q[i] <= entries_d[i];
      count_q <= count_d;
      off_q   <= off_d;
      state_q <= state_d;
      chars_q <= chars_d;
      dp_q    <= dp_d;
      full_q  <= full_d;
    end
  end

  assign chars_o = chars_q;
  assign dp_o    = dp_q;
  assign count_o = count_q;
  assign full_o  = full_q;

endmodule
